// File: rtl/multi_byte_logic_sequencer.sv
// Byte-serial logic sequencer: applies AND/OR/XOR/NOT/LSL one byte per cycle, LSB byte first.
// Optional abort input is enabled by defining LOGIC_SEQ_ABORT_EN.
module multi_byte_logic_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  zero,
  output logic                  err
`ifdef LOGIC_SEQ_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_LSL = 3'd4;

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            acc;
  logic            shift_cy;

  logic [IDXW+2:0] bit_ofs;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      res_byte;
  logic            cin;
  logic            illegal;
  logic            last;
  logic            abort_req;
  logic [W-1:0]    byte_mask;
  logic [W-1:0]    byte_ins;

  // Shared 8-bit logic unit operating on the byte selected by idx.
  always_comb begin
    bit_ofs   = {idx, 3'b000};
    a_byte    = a_q[bit_ofs +: 8];
    b_byte    = b_q[bit_ofs +: 8];
    cin       = (idx == '0) ? 1'b0 : shift_cy;
    illegal   = (op_q > OP_LSL);
    last      = (idx == IDXW'(NBYTES - 1));
    res_byte  = 8'h00;
    case (op_q)
      OP_AND:  res_byte = a_byte & b_byte;
      OP_OR:   res_byte = a_byte | b_byte;
      OP_XOR:  res_byte = a_byte ^ b_byte;
      OP_NOT:  res_byte = ~a_byte;
      OP_LSL:  res_byte = {a_byte[6:0], cin};
      default: res_byte = 8'h00;
    endcase
    byte_mask = W'(8'hFF) << bit_ofs;
    byte_ins  = W'(res_byte) << bit_ofs;
  end

`ifdef LOGIC_SEQ_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Flags settle on DONE entry and are left untouched until the next accept or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= 1'b0;
      shift_cy <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else if (abort_req) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= 1'b0;
      shift_cy <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            idx      <= '0;
            acc      <= 1'b0;
            shift_cy <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            err      <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result   <= (result & ~byte_mask) | byte_ins;
          acc      <= acc | (|res_byte);
          shift_cy <= a_byte[7];
          if (illegal) begin
            err <= 1'b1;
          end
          if (last) begin
            zero  <= ~(acc | (|res_byte));
            carry <= (op_q == OP_LSL) ? a_q[W-1] : 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
